// File: rtl/add_op_sequencer.sv
// Operand sequencer and result capture around a 4-bit ripple-carry adder.
// Optional adder self-check is built only when ADD_SELF_CHECK_EN is defined.
module add_op_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic [3:0]       add_num1,
  output logic [3:0]       add_num2,
  input  logic [3:0]       add_out,
  input  logic             add_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_sum,
  output logic             res_cout,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] ovf_count,
  output logic             check_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RESULT = 2'd2} state_t;

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       num1_q, num1_d, num2_q, num2_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] op_q, op_d, ovf_q, ovf_d;
  logic             sample;

  // Adder outputs are only trusted on the last settle cycle.
  assign sample = (state_q == SETTLE) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = valid_q;
    op_d    = op_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          num1_d  = in_a;
          num2_d  = in_b;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sample) begin
          sum_d   = add_out;
          cout_d  = add_cout;
          valid_d = 1'b1;
          state_d = RESULT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESULT: begin
        if (res_ready) begin
          valid_d = 1'b0;
          op_d    = op_q + CNT_ONE;
          if (cout_q) ovf_d = ovf_q + CNT_ONE;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num1_q  <= 4'd0;
      num2_q  <= 4'd0;
      cnt_q   <= 4'd0;
      sum_q   <= 4'd0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
      op_q    <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef ADD_SELF_CHECK_EN
  logic       err_q, err_d;
  logic [4:0] ref_sum;

  // Reference sum is taken from the held operands, not from the adder.
  assign ref_sum = {1'b0, num1_q} + {1'b0, num2_q};

  always_comb begin
    err_d = err_q;
    if (sample && ({add_cout, add_out} != ref_sum)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign check_err = err_q;
`else
  assign check_err = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign add_num1  = num1_q;
  assign add_num2  = num2_q;
  assign res_valid = valid_q;
  assign res_sum   = sum_q;
  assign res_cout  = cout_q;
  assign op_count  = op_q;
  assign ovf_count = ovf_q;

endmodule

// File: doc/add_op_sequencer.md
Name: add_op_sequencer

Overview:
- Operand sequencer and result capture stage wrapped around the 4-bit ripple-carry adder `add`.
- Accepts operand pairs over a valid/ready input handshake and drives them onto the adder's num1/num2 inputs.
- Waits a programmable settle time, then samples the adder's out/cout and presents them over a valid/ready result handshake.
- Keeps transaction and carry-out (overflow) counters for the bench and for system status.

Parameters:
- SETTLE_CYCLES, 1, cycles the operands are held on the adder before its outputs are sampled; legal range 1..15.
- CNT_W, 8, width of op_count and ovf_count.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  sequencer can accept operands
- in_a  input  4  operand A
- in_b  input  4  operand B
- add_num1  output  4  drives adder num1
- add_num2  output  4  drives adder num2
- add_out  input  4  adder sum
- add_cout  input  1  adder carry-out
- res_valid  output  1  result valid
- res_ready  input  1  consumer accepts result
- res_sum  output  4  captured sum
- res_cout  output  1  captured carry-out
- op_count  output  CNT_W  completed transactions, modulo 2^CNT_W
- ovf_count  output  CNT_W  completed transactions with res_cout=1, modulo 2^CNT_W
- check_err  output  1  sticky self-check mismatch; see Optional Feature

Behaviour:
- Single clock domain. Reset is synchronous and active-low on rst_n and takes priority over everything else.
- Reset values: state IDLE, in_ready=1, add_num1=0, add_num2=0, res_valid=0, res_sum=0, res_cout=0, op_count=0, ovf_count=0, check_err=0, settle counter=0.
- FSM states: IDLE, SETTLE, RESULT.
- in_ready is asserted exactly when state==IDLE. It is combinational from the state register.
- IDLE:
  - On in_valid&&in_ready at edge k: register in_a/in_b into the operand registers.
  - add_num1/add_num2 come from those registers and change at edge k.
  - Load the settle counter with SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE:
  - The counter decrements each cycle.
  - When the counter is 0, at that edge: sample add_out→res_sum and add_cout→res_cout, set res_valid=1, go to RESULT.
  - res_valid therefore rises at edge k+SETTLE_CYCLES.
  - in_valid is ignored in this state.
- RESULT:
  - res_sum/res_cout/res_valid are held stable until res_valid&&res_ready.
  - On that handshake edge: res_valid=0; op_count+=1; ovf_count+=1 if res_cout=1; go to IDLE.
  - res_sum/res_cout keep their last value after the handshake.
- Operand registers keep their values between transactions. add_num1/add_num2 do not return to 0 except on reset.
- No overlap:
  - Minimum spacing between accepts is SETTLE_CYCLES+2 cycles when res_ready is tied high.
  - in_valid asserted during the result handshake cycle is not accepted until the next cycle, because in_ready=0.
- Counters wrap from 2^CNT_W-1 to 0 with no saturation and no flag.
- Reset asserted during SETTLE or RESULT abandons the transaction: no count increment, and all reset values apply on that edge.
- add_out/add_cout are treated as purely combinational functions of add_num1/add_num2. No constraint is placed on them outside the sample edge.

Optional Feature:
- Macro: ADD_SELF_CHECK_EN.
- Defined:
  - At the sample edge, compare {add_cout,add_out} with the internally computed 5-bit in-house sum of the operand registers.
  - On mismatch, set check_err=1. It stays set until reset.
  - The result is still delivered unchanged, so a faulty adder is observable but not masked.
- Not defined:
  - No comparison logic is built.
  - check_err is tied to 0.
  - All other behaviour is identical.

Test Plan:
- SETTLE_CYCLES=1, res_ready=1; send 3+4 → res_sum=7, res_cout=0, res_valid high exactly 1 edge after accept; op_count=1, ovf_count=0.
- Send 9+8, then 15+15 → results (1,1) and (14,1); ovf_count=2, op_count=2; in_ready low from accept until the cycle after each result handshake.
- Hold res_ready=0 for 5 cycles after res_valid; toggle in_valid/in_a → res_sum/res_cout stable, in_ready=0, no second accept; release → single handshake, op_count increments once.
- SETTLE_CYCLES=3 → res_valid rises exactly 3 edges after accept; with CNT_W=2, four transactions → op_count wraps to 0.
- Reset pulsed during SETTLE → on that edge all outputs at reset values, counters 0, in_ready=1; the next transaction 2+2 completes normally with res_sum=4.
- ADD_SELF_CHECK_EN defined, adder model with out[2] stuck-at-0; send 4+0 → res_sum=0, check_err=1 and sticky through a later correct 1+1; without the macro, check_err stays 0.
